// File: rtl/m_stage.sv
// Memory-access stage: drives the data-memory request, formats load data and
// store lanes, stalls while memory is busy, and registers the write-back bundle.
module m_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [6:0]  m_con_in,
  input  logic [5:0]  w_con_in,
  input  logic [4:0]  em_rs2,
  output logic [31:0] em_data,
  output logic        em_regfile_we,
  output logic [4:0]  em_rd,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mw_data,
  output logic        mw_regfile_we,
  output logic [4:0]  mw_rd,
  output logic        misaligned
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mw_data_q, mw_data_d;
  logic        mw_we_q, mw_we_d;
  logic [4:0]  mw_rd_q, mw_rd_d;
  logic        mis_q, mis_d;

  logic        mem_rd, mem_wr, access, is_byte, is_half, misal_cond, fwd;
  logic [2:0]  f3;
  logic [1:0]  a;
  logic [31:0] st_src, lane_data, shifted, load_data;
  logic        unused_bits;

  assign unused_bits   = ^m_con_in[6:5];
  assign em_data       = alu_result;
  assign em_regfile_we = w_con_in[0];
  assign em_rd         = w_con_in[5:1];
  assign dmem_addr     = {alu_result[31:2], 2'b00};
  assign mw_data       = mw_data_q;
  assign mw_regfile_we = mw_we_q;
  assign mw_rd         = mw_rd_q;
  assign misaligned    = mis_q;

  always_comb begin
    mem_rd     = m_con_in[0];
    mem_wr     = m_con_in[1];
    f3         = m_con_in[4:2];
    a          = alu_result[1:0];
    access     = mem_rd | mem_wr;
    is_byte    = (f3[1:0] == 2'b00);
    is_half    = (f3[1:0] == 2'b01);
    misal_cond = access & ((is_half & a[0]) | (~is_byte & ~is_half & (a != 2'b00)));
    // Forward the value W is about to write when it is this store's rs2.
    fwd        = mem_wr & mw_we_q & (mw_rd_q == em_rs2) & (mw_rd_q != 5'd0);
    st_src     = fwd ? mw_data_q : write_data;
  end

  always_comb begin
    lane_data = st_src;
    dmem_be   = 4'b1111;
    if (is_byte) begin
      lane_data = {4{st_src[7:0]}};
      if (!mem_rd) dmem_be = 4'b0001 << a;
    end else if (is_half) begin
      lane_data = {2{st_src[15:0]}};
      if (!mem_rd) dmem_be = 4'b0011 << a;
    end
  end

  always_comb begin
    shifted   = dmem_rdata >> {a, 3'b000};
    load_data = dmem_rdata;
    if (is_byte)
      load_data = f3[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    else if (is_half)
      load_data = f3[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
  end

  // Reset gates the request so an abandoned WAIT drops it at once.
  assign dmem_req   = rst_n & ((state_q == S_WAIT) | (access & ~misal_cond));
  assign dmem_we    = dmem_req & mem_wr & ~mem_rd;
  assign dmem_wdata = (state_q == S_WAIT) ? wdata_q : lane_data;
  assign stall      = dmem_req & ~dmem_ready;

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: if (dmem_req && !dmem_ready) begin
        state_d = S_WAIT;
        wdata_d = lane_data;
      end
      S_WAIT: if (dmem_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mw_data_d = mw_data_q;
    mw_rd_d   = mw_rd_q;
    mw_we_d   = 1'b0;
    mis_d     = 1'b0;
    if (!stall) begin
      mw_rd_d   = w_con_in[5:1];
      mw_we_d   = w_con_in[0] & ~misal_cond;
      mis_d     = misal_cond;
      mw_data_d = mem_rd ? load_data : alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wdata_q   <= 32'h0;
      mw_data_q <= 32'h0;
      mw_we_q   <= 1'b0;
      mw_rd_q   <= 5'd0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdata_q   <= wdata_d;
      mw_data_q <= mw_data_d;
      mw_we_q   <= mw_we_d;
      mw_rd_q   <= mw_rd_d;
      mis_q     <= mis_d;
    end
  end

endmodule

// File: tb/tb_m_stage.sv
// Randomized bench for m_stage against an instruction-level reference model.
module tb_m_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_result = '0, write_data = '0, dmem_rdata = '0;
  logic [6:0]  m_con_in = '0;
  logic [5:0]  w_con_in = '0;
  logic [4:0]  em_rs2 = '0;
  logic        dmem_ready = 1'b0;
  logic [31:0] em_data, dmem_addr, dmem_wdata, mw_data;
  logic        em_regfile_we, stall, dmem_req, dmem_we, mw_regfile_we, misaligned;
  logic [4:0]  em_rd, mw_rd;
  logic [3:0]  dmem_be;

  int n_vec = 0, n_err = 0;

  // reference write-back state
  logic [31:0] md = '0;
  logic        mwe = 1'b0;
  logic [4:0]  mrd = '0;

  m_stage dut (
    .clk(clk), .rst_n(rst_n), .alu_result(alu_result), .write_data(write_data),
    .m_con_in(m_con_in), .w_con_in(w_con_in), .em_rs2(em_rs2), .em_data(em_data),
    .em_regfile_we(em_regfile_we), .em_rd(em_rd), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .mw_data(mw_data),
    .mw_regfile_we(mw_regfile_we), .mw_rd(mw_rd), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // access size in bytes from funct3
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [1:0] off,
                                          input logic [2:0] f3);
    int sz = size_of(f3);
    longint v;
    if (sz == 4) return rdata;
    v = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
    if (f3 < 3'd4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  // One instruction held in M until it completes; wait_n = cycles with ready low.
  task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input logic we,
                     input logic [4:0] rdi, input logic [4:0] rs2, input int wait_n,
                     input logic [31:0] rdata);
    int sz = size_of(f3);
    logic acc = rd | wr;
    logic mis = acc && (addr % sz) != 0;
    logic req = acc && !mis;
    logic st  = wr && !rd;
    logic [31:0] src, ewd, nd;
    logic [3:0]  ebe;
    int n;
    src = (wr && mwe && mrd == rs2 && mrd != 0) ? md : wd;
    if (sz == 1) begin ewd = 32'h0101_0101 * src[7:0];  ebe = 4'(1 << addr[1:0]); end
    else if (sz == 2) begin ewd = 32'h0001_0001 * src[15:0]; ebe = 4'(3 << addr[1:0]); end
    else begin ewd = src; ebe = 4'hF; end
    if (rd) ebe = 4'hF;
    alu_result = addr; write_data = wd; em_rs2 = rs2;
    m_con_in = {2'($urandom), f3, wr, rd};
    w_con_in = {rdi, we};
    n = req ? wait_n : 0;
    for (int k = 0; k <= n; k++) begin
      dmem_ready = (k == n);
      dmem_rdata = (k == n) ? rdata : $urandom;
      #3;
      chk("dmem_req", dmem_req, req);
      chk("stall", stall, req && k < n);
      if (k == 0) begin
        chk("em_data", em_data, addr);
        chk("em_fwd", {em_rd, em_regfile_we}, {rdi, we});
      end
      if (req) begin
        chk("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("dmem_be", dmem_be, ebe);
        chk("dmem_we", dmem_we, st);
        if (st) chk("dmem_wdata", dmem_wdata, ewd);
      end
      if (k > 0) begin
        chk("bubble_we", mw_regfile_we, 0);
        chk("bubble_hold", {mw_rd, mw_data}, {mrd, md});
      end
      @(posedge clk); #1;
    end
    nd  = rd ? exp_load(rdata, addr[1:0], f3) : addr;
    md  = nd;
    mwe = we && !mis;
    mrd = rdi;
    chk("mw_data", mw_data, md);
    chk("mw_regfile_we", mw_regfile_we, mwe);
    chk("mw_rd", mw_rd, mrd);
    chk("misaligned", misaligned, mis);
  endtask

  initial begin
    #2;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mw", {misaligned, mw_regfile_we, mw_rd, mw_data}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // LB sign-extended from byte 3
    run(1, 0, 3'd0, 32'h103, 0, 1, 5'd3, 0, 0, 32'h80FF_1234);
    // LHU upper half
    run(1, 0, 3'd5, 32'h102, 0, 1, 5'd4, 0, 0, 32'hBEEF_0000);
    // x5 = 0xAA, then SB with rs2 forwarded
    run(0, 0, 3'd0, 32'hAA, 0, 1, 5'd5, 0, 0, 0);
    run(0, 1, 3'd0, 32'h201, 32'h11, 0, 5'd0, 5'd5, 0, 0);
    // LW with three wait states
    run(1, 0, 3'd2, 32'h300, 0, 1, 5'd6, 0, 3, 32'hCAFE_F00D);
    // forwarded SB held through three wait states
    run(0, 0, 3'd0, 32'h5C, 0, 1, 5'd7, 0, 0, 0);
    run(0, 1, 3'd0, 32'h202, 32'h11, 0, 5'd0, 5'd7, 3, 0);
    // misaligned LW, then a plain op to see the pulse drop
    run(1, 0, 3'd2, 32'h102, 0, 1, 5'd8, 0, 2, 32'h1234_5678);
    run(0, 0, 3'd0, 32'h77, 0, 1, 5'd9, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic [1:0] kind = 2'($urandom);
      logic [31:0] ad = $urandom;
      if ($urandom_range(0, 2) != 0) ad[1:0] = 2'b00;
      run(kind[0], kind[1], 3'($urandom), ad, $urandom, 1'($urandom),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3), $urandom);
    end

    // reset while waiting: request and stall drop before the next edge
    run(0, 0, 3'd0, 32'h1234, 0, 1, 5'd10, 0, 0, 0);
    alu_result = 32'h400; m_con_in = 7'b0001001; w_con_in = {5'd11, 1'b1};
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    chk("wait_stall", stall, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_req", dmem_req, 0);
    chk("rstw_stall", stall, 0);
    chk("rstw_mw", {misaligned, mw_regfile_we, mw_rd, mw_data}, 0);
    m_con_in = '0; w_con_in = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    md = '0; mwe = 1'b0; mrd = '0;
    run(1, 0, 3'd4, 32'h401, 0, 1, 5'd12, 0, 0, 32'h0000_9C00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/m_stage.md
# m_stage

Memory-access pipeline stage of the five-stage RISC-V core, sitting between the execute stage and the write-back register. Consumes the execute stage's registered outputs (ALU result, store data, memory/write-back control, rs2 index) and drives the single-port data-memory request/ready interface. Formats load data and store byte-enables. Registers the write-back bundle, and provides the `em_data` forwarding value to execute. Stalls the pipeline while memory is not ready.

## Interface
Parameters:
- none (32-bit datapath, 5-bit register indices fixed)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_result`  in  32  address (loads/stores) or result (other ops), from execute
- `write_data`  in  32  store data, from execute
- `m_con_in`  in  7  [0] mem_read, [1] mem_write, [4:2] funct3, [6:5] reserved (ignored)
- `w_con_in`  in  6  [0] regfile_we, [5:1] rd
- `em_rs2`  in  5  rs2 index of the instruction in M
- `em_data`  out  32  = `alu_result` (combinational forwarding value)
- `em_regfile_we`  out  1  = `w_con_in[0]`
- `em_rd`  out  5  = `w_con_in[5:1]`
- `stall`  out  1  freeze upstream stages; execute holds all inputs stable while high
- `dmem_req`  out  1  access request
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  32  `{alu_result[31:2], 2'b00}`
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  store data, lane-replicated
- `dmem_ready`  in  1  access completes this cycle; may be high on the request cycle
- `dmem_rdata`  in  32  valid when `dmem_ready` is high on a read
- `mw_data`  out  32  registered write-back data
- `mw_regfile_we`  out  1  registered write enable
- `mw_rd`  out  5  registered destination
- `misaligned`  out  1  registered one-cycle pulse: the access was misaligned and was suppressed

## Operation
- Access = mem_read or mem_write. If both are set, treat it as a read.
- Size/sign from funct3:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW
  - 100 LBU, 101 LHU
  - Any other value: treat as word.
- Misaligned cases: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Never issue `dmem_req`.
  - Never stall.
  - Write-back: `mw_regfile_we`←0, `misaligned`←1.
- Store-data forwarding: if mem_write, `mw_regfile_we`=1, `mw_rd`==`em_rs2`, and `mw_rd`≠0, the source is the current `mw_data`. Otherwise the source is `write_data`.
- Store lane placement:
  - Byte: data[7:0] replicated ×4; be = 0001 << addr[1:0].
  - Half: data[15:0] replicated ×2; be = 0011 << addr[1:0].
  - Word: be = 1111.
  - Loads: be = 1111.
- Load extract: select byte/half by addr[1:0], then sign- or zero-extend per funct3.
- FSM states:
  - IDLE (reset state):
    - An aligned access asserts `dmem_req`, with `dmem_wdata` taken from the forwarding mux.
    - If `dmem_ready`=1: the access completes this cycle; stay in IDLE.
    - Otherwise: latch the resolved store data into `wdata_q` and go to WAIT.
  - WAIT:
    - `dmem_req`=1 and `dmem_wdata`=`wdata_q`.
    - When `dmem_ready`=1, go to IDLE.
- `stall` = `dmem_req` & ~`dmem_ready`.
- Write-back register update, every cycle:
  - While `stall`: insert a bubble (`mw_regfile_we`←0; `mw_data` and `mw_rd` hold).
  - Otherwise:
    - `mw_rd`←rd.
    - `mw_regfile_we`←regfile_we & ~misaligned_cond.
    - `mw_data`← formatted load data for a read, otherwise `alu_result`.

## Timing
- Reset values, asynchronous:
  - state=IDLE
  - `mw_data`=0, `mw_rd`=0, `mw_regfile_we`=0
  - `misaligned`=0, `wdata_q`=0
- Combinational outputs when inputs are idle: `dmem_req`=0, `stall`=0.
- Zero-wait access: `mw_*` update on the edge after the request cycle (1-cycle latency).
- N wait cycles: `stall` is high for N cycles and `mw_*` update on the edge at which `dmem_ready`=1.
- During WAIT, the forwarding mux is ignored: `mw_data` is a bubble-held value and must not be re-sampled.
- `dmem_req`, `dmem_we`, `dmem_addr`, and `dmem_be` stay stable throughout WAIT.
- Reset asserted in WAIT: return to IDLE immediately and drop `dmem_req`. The memory must tolerate an abandoned request.
- A non-access instruction never stalls.
- Back-to-back accesses with zero wait sustain 1 per cycle.

## Test plan
- Reset:
  - Stimulus: `rst_n`=0 while in WAIT with `dmem_ready`=0.
  - Required: `dmem_req`=0, `stall`=0, and all `mw_*`=0 before the next edge.
- LB with sign extension:
  - Stimulus: addr 0x103, `dmem_rdata`=0x80FF_1234, zero-wait.
  - Required: `dmem_be`=1111 and `dmem_addr`=0x100, then next cycle `mw_data`=0xFFFF_FF80.
- LHU on the upper half:
  - Stimulus: addr 0x102, rdata 0xBEEF_0000.
  - Required: `mw_data`=0x0000_BEEF.
- SB with forwarding:
  - Stimulus: previous instruction wrote x5=0xAA in W, `em_rs2`=5, `write_data`=0x11, addr 0x201.
  - Required: `dmem_wdata`=0xAAAA_AAAA and `dmem_be`=0010.
- Wait states:
  - Stimulus: LW with `dmem_ready` low for 3 cycles; store case uses the forwarded value as above.
  - Required:
    - `stall` high for exactly 3 cycles.
    - `mw_regfile_we`=0 during the stall.
    - The store keeps the latched `dmem_wdata` through the wait.
    - `mw_data`=rdata one edge after ready.
- Misaligned:
  - Stimulus: LW at 0x102.
  - Required: no `dmem_req`, no stall, next cycle `misaligned`=1 and `mw_regfile_we`=0, then `misaligned`=0.
